// File: rtl/mode_sum_delay_if.sv
// Sample bus for the mode-sum delay block: interleaved I/Q inputs from the
// two cavity modes and the direct reflection, plus the delayed summed output.
interface mode_sum_delay_if #(
    parameter int DW = 19,
    parameter int AW = 6
);
    logic                 iq;
    logic signed [DW-1:0] mode_a;
    logic signed [DW-1:0] mode_b;
    logic signed [DW-1:0] direct;
    logic [AW-1:0]        delay;
    logic                 sat_clr;
    logic signed [DW-1:0] out;
    logic                 out_iq;
    logic                 out_valid;
    logic                 sat;

    modport master (
        output iq, mode_a, mode_b, direct, delay, sat_clr,
        input  out, out_iq, out_valid, sat
    );

    modport slave (
        input  iq, mode_a, mode_b, direct, delay, sat_clr,
        output out, out_iq, out_valid, sat
    );
endinterface

// File: rtl/mode_sum_delay.sv
// Sums two cavity-mode streams with the direct reflection, saturates the
// result and delays it by an even number of cycles through a circular RAM,
// keeping I/Q pairing intact. Fill gating keeps stale RAM data off the output.
module mode_sum_delay #(
    parameter int DW = 19,
    parameter int AW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mode_sum_delay_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam logic signed [DW+1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SMIN = {3'b111, {(DW-1){1'b0}}};

    logic signed [DW+1:0] a_ext;
    logic signed [DW+1:0] b_ext;
    logic signed [DW+1:0] c_ext;
    logic signed [DW+1:0] s1;
    logic                 s1_iq;
    logic                 v1;
    logic signed [DW-1:0] s2_next;
    logic                 clamp;
    logic signed [DW-1:0] s2;
    logic                 s2_iq;
    logic                 v2;
    logic                 sat_r;
    logic [AW-1:0]        d_new;
    logic [AW-1:0]        d_reg;
    logic [AW-1:0]        fill;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_addr;
    logic [DW:0]          ram [DEPTH];
    logic [DW:0]          rd_word;
    logic                 filled;
    logic signed [DW-1:0] out_r;
    logic                 out_iq_r;
    logic                 out_valid_r;
    logic                 unused_delay_lsb;

    assign a_ext = bus.mode_a;
    assign b_ext = bus.mode_b;
    assign c_ext = bus.direct;

    // The delay LSB is dropped so an I sample always comes back out as an I sample.
    assign d_new            = {bus.delay[AW-1:1], 1'b0};
    assign unused_delay_lsb = bus.delay[0];

    // Stage 1: full-precision three-way sum with its iq tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            s1_iq <= 1'b0;
            v1    <= 1'b0;
        end else begin
            s1    <= a_ext + b_ext + c_ext;
            s1_iq <= bus.iq;
            v1    <= 1'b1;
        end
    end

    // Clamp the stage-1 sum into the DW-bit output range and flag when that happens.
    always_comb begin
        clamp   = 1'b0;
        s2_next = s1[DW-1:0];
        if (s1 > SMAX) begin
            clamp   = 1'b1;
            s2_next = SMAX[DW-1:0];
        end else if (s1 < SMIN) begin
            clamp   = 1'b1;
            s2_next = SMIN[DW-1:0];
        end
    end

    // Stage 2: saturated sample, plus a sticky flag where a clamp beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2    <= '0;
            s2_iq <= 1'b0;
            v2    <= 1'b0;
            sat_r <= 1'b0;
        end else begin
            s2    <= s2_next;
            s2_iq <= s1_iq;
            v2    <= v1;
            sat_r <= clamp | (sat_r & ~bus.sat_clr);
        end
    end

    // Delay is only taken on I cycles; any change restarts the fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg  <= '0;
            fill   <= '0;
            wr_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + 1'b1;
            if (s2_iq && (d_new != d_reg)) begin
                d_reg <= d_new;
                fill  <= '0;
            end else if (fill != {AW{1'b1}}) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Circular sample store; contents are never reset since fill gating hides them.
    always_ff @(posedge clk) begin
        ram[wr_ptr] <= {s2_iq, s2};
    end

    assign rd_addr = wr_ptr - d_reg;
    assign rd_word = (d_reg == '0) ? {s2_iq, s2} : ram[rd_addr];
    assign filled  = v2 && (fill >= d_reg);

    // Output register: real data once filled, zeros otherwise; iq keeps alternating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_iq_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= filled;
            if (filled) begin
                out_r    <= rd_word[DW-1:0];
                out_iq_r <= rd_word[DW];
            end else begin
                out_r    <= '0;
                out_iq_r <= s2_iq;
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.out_iq    = out_iq_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sat       = sat_r;
endmodule

// File: tb/tb_mode_sum_delay.sv
// Directed bench for mode_sum_delay: sum, saturation and sticky flag, delay
// with LSB ignored, pointer wrap, delay change refill and mid-stream reset.
module tb_mode_sum_delay;
    localparam int DW = 19;
    localparam int AW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   hist [0:2047];
    bit   ramp_on  = 1'b0;
    int   ramp_val = 0;

    mode_sum_delay_if #(.DW(DW), .AW(AW)) bus ();

    mode_sum_delay #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic int sat_model(input int s);
        if (s > 262143)  return 262143;
        if (s < -262144) return -262144;
        return s;
    endfunction

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int a, input int b, input int d);
        bus.mode_a = DW'(a);
        bus.mode_b = DW'(b);
        bus.direct = DW'(d);
    endtask

    // One clock: log the reference sum seen at this edge, then move inputs on.
    task automatic step_cycle();
        @(posedge clk);
        cyc++;
        if (cyc < 2048)
            hist[cyc] = sat_model(int'(bus.mode_a) + int'(bus.mode_b) + int'(bus.direct));
        #1;
        bus.iq = ~bus.iq;
        if (ramp_on) begin
            ramp_val++;
            apply_stimulus(3 * ramp_val, 7, -ramp_val);
        end
    endtask

    // Impulse on an I cycle must reappear exactly 13 cycles later for delay 10.
    task automatic impulse_test(input string tag);
        if (bus.iq !== 1'b1) step_cycle();
        bus.mode_a = 19'sd5000;
        step_cycle();
        bus.mode_a = '0;
        repeat (11) step_cycle();
        check_output({tag, "_pre"}, bus.out, 0);
        step_cycle();
        check_output({tag, "_out"}, bus.out, 5000);
        check_output({tag, "_iq"}, bus.out_iq, 1);
        step_cycle();
        check_output({tag, "_post"}, bus.out, 0);
    endtask

    // Watch a refill: the last invalid run must be d_eff long with zero data,
    // and the data afterwards must arrive at latency d_eff + 3.
    task automatic check_refill(input string tag, input int n_cycles, input int d_eff);
        int run      = 0;
        int last_run = 0;
        bit zero_ok  = 1'b1;
        repeat (n_cycles) begin
            step_cycle();
            if (bus.out_valid !== 1'b1) begin
                run++;
                if (bus.out !== '0) zero_ok = 1'b0;
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
        end
        check_output({tag, "_gap"}, last_run, d_eff);
        check_output({tag, "_zero"}, zero_ok, 1);
        check_output({tag, "_valid"}, bus.out_valid, 1);
        check_output({tag, "_data"}, bus.out, hist[cyc - 2 - d_eff]);
    endtask

    // Linear sequence of directed steps.
    initial begin
        bit hold_ok;
        bus.iq      = 1'b0;
        bus.delay   = '0;
        bus.sat_clr = 1'b0;
        apply_stimulus(0, 0, 0);
        repeat (3) step_cycle();
        check_output("rst_out", bus.out, 0);
        check_output("rst_out_iq", bus.out_iq, 0);
        check_output("rst_valid", bus.out_valid, 0);
        check_output("rst_sat", bus.sat, 0);

        rst_n = 1'b1;
        apply_stimulus(1000, -200, 50);
        step_cycle();
        step_cycle();
        check_output("sum_valid_early", bus.out_valid, 0);
        step_cycle();
        check_output("sum_out", bus.out, 850);
        check_output("sum_valid", bus.out_valid, 1);
        check_output("sum_sat", bus.sat, 0);

        apply_stimulus(200000, 200000, 100000);
        repeat (3) step_cycle();
        check_output("satpos_out", bus.out, 262143);
        check_output("satpos_flag", bus.sat, 1);
        apply_stimulus(-200000, -200000, -100000);
        repeat (3) step_cycle();
        check_output("satneg_out", bus.out, -262144);
        apply_stimulus(1, 2, 3);
        repeat (2) step_cycle();
        bus.sat_clr = 1'b1;
        step_cycle();
        bus.sat_clr = 1'b0;
        check_output("satclr_flag", bus.sat, 0);

        apply_stimulus(200000, 200000, 100000);
        step_cycle();
        check_output("satboth_before", bus.sat, 0);
        bus.sat_clr = 1'b1;
        step_cycle();
        bus.sat_clr = 1'b0;
        check_output("satboth_flag", bus.sat, 1);
        apply_stimulus(1, 2, 3);
        repeat (2) step_cycle();
        bus.sat_clr = 1'b1;
        step_cycle();
        bus.sat_clr = 1'b0;
        check_output("satclr2_flag", bus.sat, 0);
        repeat (2) step_cycle();
        check_output("inrange_out", bus.out, 6);

        apply_stimulus(0, 0, 0);
        bus.delay = 6'd10;
        repeat (30) step_cycle();
        check_output("d10_valid", bus.out_valid, 1);
        impulse_test("d10");

        bus.delay = 6'd11;
        hold_ok = 1'b1;
        repeat (20) begin
            step_cycle();
            if (bus.out_valid !== 1'b1) hold_ok = 1'b0;
        end
        check_output("d11_no_refill", hold_ok, 1);
        impulse_test("d11");

        bus.delay = 6'd62;
        ramp_on   = 1'b1;
        repeat (80) step_cycle();
        for (int k = 0; k < 300; k++) begin
            step_cycle();
            check_output("wrap_data", bus.out, hist[cyc - 64]);
        end
        check_output("wrap_valid", bus.out_valid, 1);

        bus.delay = 6'd4;
        repeat (20) step_cycle();
        check_output("d4_data", bus.out, hist[cyc - 6]);
        bus.delay = 6'd20;
        check_refill("chg", 45, 20);

        rst_n = 1'b0;
        #1;
        check_output("midrst_out", bus.out, 0);
        check_output("midrst_out_iq", bus.out_iq, 0);
        check_output("midrst_valid", bus.out_valid, 0);
        check_output("midrst_sat", bus.sat, 0);
        step_cycle();
        rst_n = 1'b1;
        check_refill("rst", 45, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mode_sum_delay.md
MODE_SUM_DELAY -- requirements
Module: mode_sum_delay

Interface
REQ-001 Parameter: DW, default 19, sample width of all data ports.
REQ-002 Parameter: AW, default 6, delay-buffer address width; depth 2^AW samples.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: iq  in  1  high marks I sample, low marks Q sample; alternates every cycle.
REQ-006 Port: mode_a  in  DW signed  interleaved probe/reflected stream from first cavity mode.
REQ-007 Port: mode_b  in  DW signed  same, second cavity mode, time-aligned with mode_a.
REQ-008 Port: direct  in  DW signed  direct reflection of forward wave, same interleave.
REQ-009 Port: delay  in  AW  requested coarse delay in cycles; LSB ignored.
REQ-010 Port: sat_clr  in  1  clears sticky saturation flag.
REQ-011 Port: out  out  DW signed  delayed, summed sample.
REQ-012 Port: out_iq  out  1  iq tag aligned with out.
REQ-013 Port: out_valid  out  1  high when out holds buffered data, not fill zeros.
REQ-014 Port: sat  out  1  sticky flag, set on any sum saturation.

Function
REQ-015 Stage 1: register s1 = mode_a + mode_b + direct at DW+2 bits, full precision, plus iq.
REQ-016 Stage 2: saturate s1 to DW bits: clamp to +(2^(DW-1)-1) or -(2^(DW-1)); register result and iq.
REQ-017 A clamp event in stage 2 sets sat the following cycle; sat holds until sat_clr.
REQ-018 sat_clr and a clamp event in the same cycle leave sat set.
REQ-019 Effective delay D = {delay[AW-1:1],1'b0}, so I/Q pairing is preserved.
REQ-020 delay is sampled into D_reg only on cycles where stage-2 iq is high.
REQ-021 The buffer is a circular RAM of 2^AW x (DW+1) holding sample and iq tag; write pointer increments every cycle and wraps from 2^AW-1 to 0.
REQ-022 Read address = write pointer minus D_reg, modulo 2^AW.
REQ-023 When D_reg = 0 the stage-2 output bypasses the RAM; no read-during-write hazard.
REQ-024 Output register: out and out_iq update every cycle; total latency from input to out is D_reg + 3 cycles.
REQ-025 A fill counter, saturating at 2^AW-1, counts cycles since reset or since the last change of D_reg.
REQ-026 While fill count < D_reg, out = 0, out_valid = 0, and out_iq still follows the stage-2 iq delayed by D_reg + 1.
REQ-027 When D_reg changes, the fill counter restarts at 0; out_valid drops the next cycle and returns after D_reg new cycles.
REQ-028 When D_reg = 0, out_valid is high 3 cycles after reset release.
REQ-029 RAM contents need no reset; fill gating keeps stale data off out.

Reset
REQ-030 While rst_n is low: out = 0, out_iq = 0, out_valid = 0, sat = 0, pointers = 0, fill = 0, D_reg = 0, pipeline registers = 0.
REQ-031 Reset asserted mid-operation discards all buffered data; behaviour after release matches power-up.

Verification
REQ-032 Sum: mode_a = 1000, mode_b = -200, direct = 50, delay = 0 -> out = 850 at cycle 3, out_valid = 1, sat = 0.
REQ-033 Saturation: mode_a = mode_b = 200000, direct = 100000 -> out = 262143 and sat = 1; pulse sat_clr with in-range data -> sat = 0.
REQ-034 Delay: impulse of 5000 on the I cycle, delay = 10 -> out = 5000 exactly 13 cycles later with out_iq = 1; delay = 11 gives the same result.
REQ-035 Wrap: delay = 62, run 300 cycles of a ramp -> every out equals the input from 65 cycles earlier, with no glitch at pointer wrap.
REQ-036 Delay change: switch delay 4 -> 20 mid-stream -> out = 0 and out_valid = 0 for 20 cycles, then correct data at latency 23.
REQ-037 Reset mid-stream: drop rst_n for 1 cycle during delay = 20 -> all outputs 0 at once, and the refill sequence matches REQ-036.
